ps2_kbd_ctrl: RTL and testbench
===============================

// Module: ps2_kbd_ctrl
// PURPOSE
//  Sequencing controller between the PS/2 receiver and the CPU bus.
//  - Gates the receiver with rx_en and consumes its rx_done_tick/dout byte stream.
//  - Folds the 0xE0 (extended) and 0xF0 (break) prefixes into one key event.
//  - Buffers events in a small first-word-fall-through (FWFT) FIFO, which the
//    CPU pops with a one-cycle rd strobe.
// PARAMETERS
//  FIFO_DEPTH   8          event FIFO entries; must be a power of 2
//  FIFO_AW      3          log2(FIFO_DEPTH); count register is FIFO_AW+1 bits
//  TIMEOUT_CYC  2500000    prefix watchdog limit in clk cycles (50 ms @ 50 MHz)
// PORTS
//  clk          in   1   system clock; all logic is on the rising edge
//  reset        in   1   asynchronous, active-high reset
//  rx_done_tick in   1   one-cycle strobe from the receiver: a byte is valid
//  rx_data      in   8   receiver byte; sampled only when rx_done_tick=1
//  rx_en        out  1   receive enable to the receiver
//  rd           in   1   CPU pop strobe, one cycle
//  evt_valid    out  1   FIFO not empty; head event is on evt_*
//  evt_code     out  8   head scan code, prefixes stripped
//  evt_ext      out  1   head event was preceded by 0xE0
//  evt_break    out  1   head event was preceded by 0xF0 (key release)
//  fifo_full    out  1   count == FIFO_DEPTH
//  overflow     out  1   sticky: an event was dropped because the FIFO was full
//  ovf_clr      in   1   clears overflow; a set in the same cycle wins
// BEHAVIOUR
//  Reset values:
//  - state=IDLE, ext_flag=0, brk_flag=0, FIFO pointers and count = 0.
//  - Outputs: rx_en=1, evt_valid=0, evt_code=0, evt_ext=0, evt_break=0,
//    fifo_full=0, overflow=0.
//  - Reset mid-frame discards the prefix flags and all FIFO contents.
//  rx_en:
//  - rx_en = ~fifo_full, registered.
//  - Because it is registered, rx_en goes low the cycle after the push that fills the FIFO.
//  State machine:
//  - IDLE: rx_done_tick with 0xE0 -> ext_flag=1, go to PFX.
//    rx_done_tick with 0xF0 -> brk_flag=1, go to PFX.
//    rx_done_tick with any other byte -> latch {ext_flag, brk_flag, byte}, go to PUSH.
//  - PFX: same byte decode as IDLE. Flags accumulate by OR, so E0,F0,xx gives
//    ext=1, brk=1. A repeated prefix is idempotent.
//  - PUSH: write the latched event if count < FIFO_DEPTH, else set overflow and
//    drop it. Clear both flags. Always return to IDLE.
//    A rx_done_tick arriving in PUSH is ignored; the receiver's frame time makes
//    this impossible in practice.
//  - 0xE1, 0xAA, 0xFA, 0xFE and every other byte are ordinary codes, pushed as-is.
//  Latency and FIFO:
//  - rx_done_tick in cycle N (non-prefix byte) -> evt_valid/evt_* reflect the event
//    from cycle N+2 when the FIFO was empty.
//  - FWFT: evt_* always show the head entry; their values are undefined-free
//    (hold the last value) when evt_valid=0.
//  - rd with evt_valid=1 pops on that edge and the next entry appears the following cycle.
//  - rd with evt_valid=0 is ignored; count never underflows.
//  - Push and pop in the same cycle: both happen and count is unchanged.
//    This holds when full: the pop frees the slot, no drop, overflow not set.
//  - Pointers wrap modulo FIFO_DEPTH; count saturates by construction at 0..FIFO_DEPTH.
// CONFIGURATION
//  KBD_TIMEOUT_EN defined:
//  - A counter runs while in PFX and restarts on every rx_done_tick.
//  - When the counter reaches TIMEOUT_CYC-1, both flags clear and state goes to IDLE
//    with no push. This recovers from a lost byte after a prefix.
//  KBD_TIMEOUT_EN undefined:
//  - No counter is built; PFX holds indefinitely until the next byte.
//  Ports are identical in both builds.
// TESTING
//  1. Reset, then byte 0x1C -> evt_valid=1 at N+2; code=0x1C, ext=0, break=0; rd -> evt_valid=0.
//  2. Bytes F0,1C -> a single event: code=0x1C, break=1, ext=0.
//     Bytes E0,F0,75 -> code=0x75, ext=1, break=1.
//  3. Push 8 codes without rd -> fifo_full=1, rx_en=0 the next cycle.
//     A 9th byte -> dropped, overflow=1. ovf_clr -> overflow=0. The 8 pops return
//     the codes in order.
//  4. FIFO full plus a simultaneous push and rd -> count stays 8, overflow stays 0,
//     and the new code is last out.
//  5. With KBD_TIMEOUT_EN and TIMEOUT_CYC=16: E0, idle 20 cycles, then 0x1C
//     -> event ext=0. Without the macro, the same stimulus gives ext=1.
//  6. Assert reset while in PFX with 3 entries queued -> all outputs return to reset
//     values; the next byte 0x2A -> code=0x2A, ext=0, break=0.

Source files
------------

// File: rtl/ps2_kbd_ctrl_if.sv
// Receiver/CPU-side signal bundle for ps2_kbd_ctrl.
// master = receiver + CPU side, slave = the controller.
interface ps2_kbd_ctrl_if;
  logic       rx_done_tick;
  logic [7:0] rx_data;
  logic       rx_en;
  logic       rd;
  logic       evt_valid;
  logic [7:0] evt_code;
  logic       evt_ext;
  logic       evt_break;
  logic       fifo_full;
  logic       overflow;
  logic       ovf_clr;

  modport master (
    output rx_done_tick, rx_data, rd, ovf_clr,
    input  rx_en, evt_valid, evt_code, evt_ext, evt_break, fifo_full, overflow
  );

  modport slave (
    input  rx_done_tick, rx_data, rd, ovf_clr,
    output rx_en, evt_valid, evt_code, evt_ext, evt_break, fifo_full, overflow
  );
endinterface

// File: rtl/ps2_kbd_ctrl.sv
// PS/2 keyboard sequencer: folds E0/F0 prefixes into key events and queues them in a FWFT FIFO.
// Optional prefix watchdog enabled by defining KBD_TIMEOUT_EN.
module ps2_kbd_ctrl #(
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned FIFO_AW     = 3,
  parameter int unsigned TIMEOUT_CYC = 2500000
) (
  input  logic           clk,
  input  logic           reset,
  ps2_kbd_ctrl_if.slave  kbd
);

  if (FIFO_DEPTH != (1 << FIFO_AW) || TIMEOUT_CYC == 0) begin : g_param_check
    $error("ps2_kbd_ctrl: inconsistent FIFO_DEPTH/FIFO_AW or zero TIMEOUT_CYC");
  end

  typedef enum logic [1:0] {S_IDLE, S_PFX, S_PUSH} state_t;

  localparam logic [FIFO_AW:0] DEPTH_C = (FIFO_AW+1)'(FIFO_DEPTH);

  state_t             state_q, state_d;
  logic               ext_flag_q, ext_flag_d;
  logic               brk_flag_q, brk_flag_d;
  logic [7:0]         lat_code_q, lat_code_d;
  logic               lat_ext_q, lat_ext_d;
  logic               lat_brk_q, lat_brk_d;
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   count_q, count_d;
  logic [9:0]         hold_q, hold_d;
  logic               rx_en_q, rx_en_d;
  logic               ovf_q, ovf_d;

  logic [9:0]         mem_q [FIFO_DEPTH];
  logic [9:0]         head;
  logic               full, empty, push, pop, drop;
  logic               is_e0, is_f0;

`ifdef KBD_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          to_hit;

  always_comb begin
    to_hit   = (state_q == S_PFX) && (to_cnt_q == TO_LAST);
    to_cnt_d = (kbd.rx_done_tick || state_q != S_PFX) ? '0 : to_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) to_cnt_q <= '0;
    else       to_cnt_q <= to_cnt_d;
  end
`else
  logic to_hit;
  assign to_hit = 1'b0;
`endif

  always_comb begin
    full  = (count_q == DEPTH_C);
    empty = (count_q == '0);
    pop   = kbd.rd && !empty;
    is_e0 = (kbd.rx_data == 8'hE0);
    is_f0 = (kbd.rx_data == 8'hF0);
    head  = empty ? hold_q : mem_q[rd_ptr_q];

    state_d    = state_q;
    ext_flag_d = ext_flag_q;
    brk_flag_d = brk_flag_q;
    lat_code_d = lat_code_q;
    lat_ext_d  = lat_ext_q;
    lat_brk_d  = lat_brk_q;
    push       = 1'b0;
    drop       = 1'b0;

    case (state_q)
      S_IDLE, S_PFX: begin
        if (kbd.rx_done_tick) begin
          if (is_e0) begin
            ext_flag_d = 1'b1;
            state_d    = S_PFX;
          end else if (is_f0) begin
            brk_flag_d = 1'b1;
            state_d    = S_PFX;
          end else begin
            lat_code_d = kbd.rx_data;
            lat_ext_d  = ext_flag_q;
            lat_brk_d  = brk_flag_q;
            state_d    = S_PUSH;
          end
        end else if (to_hit) begin
          ext_flag_d = 1'b0;
          brk_flag_d = 1'b0;
          state_d    = S_IDLE;
        end
      end
      S_PUSH: begin
        // A same-cycle pop frees the slot, so a full FIFO still accepts the event.
        if (!full || pop) push = 1'b1;
        else              drop = 1'b1;
        ext_flag_d = 1'b0;
        brk_flag_d = 1'b0;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;

    ovf_d   = drop ? 1'b1 : (kbd.ovf_clr ? 1'b0 : ovf_q);
    rx_en_d = !full;
    hold_d  = head;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      ext_flag_q <= 1'b0;
      brk_flag_q <= 1'b0;
      lat_code_q <= '0;
      lat_ext_q  <= 1'b0;
      lat_brk_q  <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      hold_q     <= '0;
      rx_en_q    <= 1'b1;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ext_flag_q <= ext_flag_d;
      brk_flag_q <= brk_flag_d;
      lat_code_q <= lat_code_d;
      lat_ext_q  <= lat_ext_d;
      lat_brk_q  <= lat_brk_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      hold_q     <= hold_d;
      rx_en_q    <= rx_en_d;
      ovf_q      <= ovf_d;
    end
  end

  // Storage needs no reset: it is only visible through head when count is nonzero.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {lat_ext_q, lat_brk_q, lat_code_q};
  end

  assign kbd.rx_en     = rx_en_q;
  assign kbd.evt_valid = !empty;
  assign kbd.evt_ext   = head[9];
  assign kbd.evt_break = head[8];
  assign kbd.evt_code  = head[7:0];
  assign kbd.fifo_full = full;
  assign kbd.overflow  = ovf_q;

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Self-checking bench for ps2_kbd_ctrl: prefix folding table, FIFO full/overflow, timeout and reset.
module tb_ps2_kbd_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ps2_kbd_ctrl_if kif ();

  ps2_kbd_ctrl #(.FIFO_DEPTH(8), .FIFO_AW(3), .TIMEOUT_CYC(16)) dut (
    .clk   (clk),
    .reset (reset),
    .kbd   (kif.slave)
  );

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
  } evt_t;

  typedef struct {
    int unsigned n;
    logic [7:0]  b0, b1, b2;
    evt_t        exp;
  } vec_t;

  evt_t q[$];
  vec_t tbl[8];
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

`ifdef KBD_TIMEOUT_EN
  localparam logic TO_EXT = 1'b0;
`else
  localparam logic TO_EXT = 1'b1;
`endif

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input int unsigned n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b, input int unsigned gap);
    kif.rx_data = b;
    kif.rx_done_tick = 1'b1;
    cyc(1);
    kif.rx_done_tick = 1'b0;
    cyc(gap);
  endtask

  task automatic pop_check(input string nm);
    evt_t e;
    int unsigned w = 0;
    while (!kif.evt_valid && w < 50) begin cyc(1); w++; end
    chk({nm, "_valid"}, 32'(kif.evt_valid), 32'd1);
    if (q.size() == 0) begin
      n_errors++;
      $display("FAIL %s_sb: scoreboard empty, got %0h expected none", nm, kif.evt_code);
    end else begin
      e = q.pop_front();
      chk({nm, "_code"}, 32'(kif.evt_code), 32'(e.code));
      chk({nm, "_ext"}, 32'(kif.evt_ext), 32'(e.ext));
      chk({nm, "_brk"}, 32'(kif.evt_break), 32'(e.brk));
    end
    kif.rd = 1'b1;
    cyc(1);
    kif.rd = 1'b0;
  endtask

  task automatic chk_reset_outs(input string nm);
    chk({nm, "_rx_en"}, 32'(kif.rx_en), 32'd1);
    chk({nm, "_valid"}, 32'(kif.evt_valid), 32'd0);
    chk({nm, "_code"}, 32'(kif.evt_code), 32'd0);
    chk({nm, "_ext"}, 32'(kif.evt_ext), 32'd0);
    chk({nm, "_brk"}, 32'(kif.evt_break), 32'd0);
    chk({nm, "_full"}, 32'(kif.fifo_full), 32'd0);
    chk({nm, "_ovf"}, 32'(kif.overflow), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] bs [3];
    evt_t e;

    tbl[0] = '{2, 8'hF0, 8'h1C, 8'h00, '{8'h1C, 1'b0, 1'b1}};
    tbl[1] = '{3, 8'hE0, 8'hF0, 8'h75, '{8'h75, 1'b1, 1'b1}};
    tbl[2] = '{1, 8'hE1, 8'h00, 8'h00, '{8'hE1, 1'b0, 1'b0}};
    tbl[3] = '{3, 8'hE0, 8'hE0, 8'h6B, '{8'h6B, 1'b1, 1'b0}};
    tbl[4] = '{1, 8'hAA, 8'h00, 8'h00, '{8'hAA, 1'b0, 1'b0}};
    tbl[5] = '{1, 8'hFA, 8'h00, 8'h00, '{8'hFA, 1'b0, 1'b0}};
    tbl[6] = '{2, 8'hE0, 8'h4A, 8'h00, '{8'h4A, 1'b1, 1'b0}};
    tbl[7] = '{3, 8'hF0, 8'hF0, 8'hFE, '{8'hFE, 1'b0, 1'b1}};

    kif.rx_done_tick = 1'b0;
    kif.rx_data = 8'h00;
    kif.rd = 1'b0;
    kif.ovf_clr = 1'b0;
    cyc(3);
    chk_reset_outs("reset");
    reset = 1'b0;
    cyc(1);

    // Latency: tick in N, not visible in N+1, visible in N+2.
    send_byte(8'h1C, 0);
    chk("lat_n1_valid", 32'(kif.evt_valid), 32'd0);
    cyc(1);
    chk("lat_n2_valid", 32'(kif.evt_valid), 32'd1);
    q.push_back('{8'h1C, 1'b0, 1'b0});
    pop_check("lat");
    chk("lat_empty", 32'(kif.evt_valid), 32'd0);
    chk("lat_hold", 32'(kif.evt_code), 32'h1C);

    for (int i = 0; i < 8; i++) begin
      bs[0] = tbl[i].b0; bs[1] = tbl[i].b1; bs[2] = tbl[i].b2;
      for (int j = 0; j < int'(tbl[i].n); j++) send_byte(bs[j], 2);
      q.push_back(tbl[i].exp);
      pop_check($sformatf("tbl%0d", i));
    end

    // Fill, overflow, set-wins-over-clear, drain in order.
    for (int i = 0; i < 7; i++) begin
      send_byte(8'h10 + 8'(i), 2);
      q.push_back('{8'h10 + 8'(i), 1'b0, 1'b0});
    end
    send_byte(8'h17, 0);
    q.push_back('{8'h17, 1'b0, 1'b0});
    cyc(1);
    chk("fill_full", 32'(kif.fifo_full), 32'd1);
    chk("fill_rx_en_lag", 32'(kif.rx_en), 32'd1);
    cyc(1);
    chk("fill_rx_en", 32'(kif.rx_en), 32'd0);
    chk("fill_ovf0", 32'(kif.overflow), 32'd0);
    send_byte(8'h99, 0);
    cyc(1);
    chk("ovf_set", 32'(kif.overflow), 32'd1);
    chk("ovf_full", 32'(kif.fifo_full), 32'd1);
    send_byte(8'h9A, 0);
    kif.ovf_clr = 1'b1;
    cyc(1);
    kif.ovf_clr = 1'b0;
    chk("ovf_set_wins", 32'(kif.overflow), 32'd1);
    kif.ovf_clr = 1'b1;
    cyc(1);
    kif.ovf_clr = 1'b0;
    chk("ovf_clr", 32'(kif.overflow), 32'd0);
    for (int i = 0; i < 8; i++) pop_check($sformatf("drain%0d", i));
    chk("drain_empty", 32'(kif.evt_valid), 32'd0);
    kif.rd = 1'b1;
    cyc(1);
    kif.rd = 1'b0;
    chk("rd_empty", 32'(kif.evt_valid), 32'd0);
    send_byte(8'h33, 2);
    q.push_back('{8'h33, 1'b0, 1'b0});
    pop_check("no_underflow");
    chk("no_underflow_empty", 32'(kif.evt_valid), 32'd0);

    // Full FIFO with push and pop in the same cycle.
    for (int i = 0; i < 8; i++) begin
      send_byte(8'h20 + 8'(i), 2);
      q.push_back('{8'h20 + 8'(i), 1'b0, 1'b0});
    end
    chk("pp_full", 32'(kif.fifo_full), 32'd1);
    send_byte(8'h55, 0);
    e = q.pop_front();
    chk("pp_head", 32'(kif.evt_code), 32'(e.code));
    q.push_back('{8'h55, 1'b0, 1'b0});
    kif.rd = 1'b1;
    cyc(1);
    kif.rd = 1'b0;
    chk("pp_still_full", 32'(kif.fifo_full), 32'd1);
    chk("pp_no_ovf", 32'(kif.overflow), 32'd0);
    for (int i = 0; i < 8; i++) pop_check($sformatf("pp%0d", i));
    chk("pp_empty", 32'(kif.evt_valid), 32'd0);

    // Lost byte after a prefix.
    send_byte(8'hE0, 0);
    cyc(20);
    send_byte(8'h1C, 2);
    q.push_back('{8'h1C, TO_EXT, 1'b0});
    pop_check("timeout");

    // Reset while in PFX with entries queued.
    for (int i = 0; i < 3; i++) send_byte(8'h40 + 8'(i), 2);
    send_byte(8'hE0, 2);
    send_byte(8'hF0, 2);
    chk("pre_rst_valid", 32'(kif.evt_valid), 32'd1);
    reset = 1'b1;
    #1;
    chk_reset_outs("mid_rst");
    cyc(2);
    reset = 1'b0;
    q.delete();
    send_byte(8'h2A, 2);
    q.push_back('{8'h2A, 1'b0, 1'b0});
    pop_check("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
